gpr_regfile: RTL and testbench

//  Parametrised general-purpose register file; successor to the fixed 13-input GPR select mux.

---
 rtl/gpr_pkg.sv | 14 +
 rtl/gpr_read_port.sv | 42 ++++
 rtl/gpr_regfile.sv | 107 ++++++++++
 tb/tb_gpr_regfile.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared defaults, index type and range helper for the general-purpose register file.
package gpr_pkg;

  localparam int GPR_DATA_W   = 32;
  localparam int GPR_NUM_REGS = 13;
  localparam int GPR_SEL_W    = $clog2(GPR_NUM_REGS);

  typedef logic [GPR_SEL_W-1:0] gpr_idx_t;

  function automatic logic in_range(input int idx, input int n);
    return (idx < n);
  endfunction

endpackage

// File: rtl/gpr_read_port.sv
// One combinational read port: register mux, range check and optional write bypass.
module gpr_read_port
  import gpr_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int NUM_REGS = GPR_NUM_REGS,
  parameter int SEL_W    = $clog2(NUM_REGS),
  parameter int FORWARD  = 1
) (
  input  logic [NUM_REGS*DATA_W-1:0] regs_i,
  input  logic [NUM_REGS-1:0]        busy_i,
  input  logic [SEL_W-1:0]           sel_i,
  input  logic                       fwd_en_i,
  input  logic [SEL_W-1:0]           wr_sel_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       busy_o,
  output logic                       range_err_o
);

  logic sel_ok;

  assign sel_ok      = in_range(int'(sel_i), NUM_REGS);
  assign range_err_o = ~sel_ok;

  // Out-of-range selects match no entry, so they fall through to zero.
  always_comb begin
    data_o = '0;
    busy_o = 1'b0;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (sel_i == SEL_W'(n)) begin
        data_o = regs_i[n*DATA_W +: DATA_W];
        busy_o = busy_i[n];
      end
    end
    if ((FORWARD != 0) && fwd_en_i && sel_ok && (wr_sel_i == sel_i)) begin
      data_o = wr_data_i;
      busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/gpr_regfile.sv
// Parametrised register file with per-register busy bits, sticky index error and
// optional same-cycle write forwarding to the combinational read ports.
module gpr_regfile
  import gpr_pkg::*;
#(
  parameter int  DATA_W   = GPR_DATA_W,
  parameter int  NUM_REGS = GPR_NUM_REGS,
  parameter int  NUM_RD   = 2,
  parameter int  FORWARD  = 1,
  localparam int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*SEL_W-1:0]  rd_sel,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [SEL_W-1:0]         wr_sel,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [SEL_W-1:0]         rsv_sel,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic                     sel_err,
  input  logic                     err_clr
);

  logic [DATA_W-1:0]          regs_q [NUM_REGS];
  logic [DATA_W-1:0]          regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]        busy_q, busy_d;
  logic                       sel_err_q, sel_err_d;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic [NUM_RD-1:0]          rd_err;
  logic                       wr_ok, rsv_ok, any_err, fwd_en;

  assign wr_ok   = wr_en  & in_range(int'(wr_sel),  NUM_REGS);
  assign rsv_ok  = rsv_en & in_range(int'(rsv_sel), NUM_REGS);
  assign any_err = (|rd_err) | (wr_en & ~wr_ok) | (rsv_en & ~rsv_ok);

  // A write held during reset is discarded, so it must not leak onto the read ports either.
  assign fwd_en  = wr_en & rst_n;

  always_comb begin
    regs_flat = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      regs_flat[n*DATA_W +: DATA_W] = regs_q[n];
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    gpr_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .SEL_W    (SEL_W),
      .FORWARD  (FORWARD)
    ) u_port (
      .regs_i      (regs_flat),
      .busy_i      (busy_q),
      .sel_i       (rd_sel[p*SEL_W +: SEL_W]),
      .fwd_en_i    (fwd_en),
      .wr_sel_i    (wr_sel),
      .wr_data_i   (wr_data),
      .data_o      (rd_data[p*DATA_W +: DATA_W]),
      .busy_o      (rd_busy[p]),
      .range_err_o (rd_err[p])
    );
  end

  // Reserve is applied after write so a same-register reservation leaves busy set.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (wr_ok && (wr_sel == SEL_W'(n))) begin
        regs_d[n] = wr_data;
        busy_d[n] = 1'b0;
      end
      if (rsv_ok && (rsv_sel == SEL_W'(n))) begin
        busy_d[n] = 1'b1;
      end
    end
    if (any_err) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end else begin
      sel_err_d = sel_err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        regs_q[n] <= '0;
      end
      busy_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign busy_vec = busy_q;
  assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_gpr_regfile.sv
// Bench for gpr_regfile: forwarding and non-forwarding instances share stimulus and one reference model.
module tb_gpr_regfile;

  localparam int NR = 13;
  localparam int SW = 4;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [2*SW-1:0] rd_sel;
  logic          wr_en;
  logic [SW-1:0] wr_sel;
  logic [DW-1:0] wr_data;
  logic          rsv_en;
  logic [SW-1:0] rsv_sel;
  logic          err_clr;

  logic [2*DW-1:0] rd_data_f, rd_data_n;
  logic [1:0]      rd_busy_f, rd_busy_n;
  logic [NR-1:0]   busy_vec_f, busy_vec_n;
  logic            sel_err_f, sel_err_n;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;
  logic          m_err;

  gpr_regfile #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2), .FORWARD(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_sel(rd_sel), .rd_data(rd_data_f), .rd_busy(rd_busy_f),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
    .busy_vec(busy_vec_f), .sel_err(sel_err_f), .err_clr(err_clr)
  );

  gpr_regfile #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2), .FORWARD(0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .rd_sel(rd_sel), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
    .busy_vec(busy_vec_n), .sel_err(sel_err_n), .err_clr(err_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input int sel, input bit fwd);
    if (sel >= NR) return '0;
    if (fwd && rst_n && wr_en && (int'(wr_sel) == sel)) return wr_data;
    return m_regs[sel];
  endfunction

  function automatic logic exp_busy(input int sel, input bit fwd);
    if (sel >= NR) return 1'b0;
    if (fwd && rst_n && wr_en && (int'(wr_sel) == sel)) return 1'b0;
    return m_busy[sel];
  endfunction

  function automatic bit any_oor();
    return (int'(rd_sel[SW-1:0]) >= NR) || (int'(rd_sel[2*SW-1:SW]) >= NR) ||
           (wr_en && int'(wr_sel) >= NR) || (rsv_en && int'(rsv_sel) >= NR);
  endfunction

  // model update: later nonblocking assignment (reserve) wins over the write's busy clear
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_regs[i] <= '0;
      m_busy <= '0;
      m_err  <= 1'b0;
    end else begin
      m_err <= any_oor() ? 1'b1 : (err_clr ? 1'b0 : m_err);
      if (wr_en && int'(wr_sel) < NR) begin
        m_regs[int'(wr_sel)] <= wr_data;
        m_busy[int'(wr_sel)] <= 1'b0;
      end
      if (rsv_en && int'(rsv_sel) < NR) m_busy[int'(rsv_sel)] <= 1'b1;
    end
  end

  // scoreboard compare process
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      int s;
      s = int'(rd_sel[p*SW +: SW]);
      chk("rd_data_fwd", rd_data_f[p*DW +: DW], exp_data(s, 1'b1));
      chk("rd_data_nofwd", rd_data_n[p*DW +: DW], exp_data(s, 1'b0));
      chk("rd_busy_fwd", DW'(rd_busy_f[p]), DW'(exp_busy(s, 1'b1)));
      chk("rd_busy_nofwd", DW'(rd_busy_n[p]), DW'(exp_busy(s, 1'b0)));
    end
    chk("busy_vec_fwd", DW'(busy_vec_f), DW'(m_busy));
    chk("busy_vec_nofwd", DW'(busy_vec_n), DW'(m_busy));
    chk("sel_err_fwd", DW'(sel_err_f), DW'(m_err));
    chk("sel_err_nofwd", DW'(sel_err_n), DW'(m_err));
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    rd_sel = '0; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_sel = '0; err_clr = 1'b0;
    #2 rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;

    // 1: reset state sweep
    for (int s = 0; s < 16; s++) begin
      rd_sel[SW-1:0] = SW'(s);
      settle();
      chk("t1_data", rd_data_f[DW-1:0], '0);
      chk("t1_busy_vec", DW'(busy_vec_f), '0);
      chk("t1_sel_err", DW'(sel_err_f), DW'(s >= 14));
      step();
    end

    // 2: fill n = n+1, clear error, sweep
    rd_sel = '0;
    for (int n = 0; n < NR; n++) begin
      wr_en = 1'b1; wr_sel = SW'(n); wr_data = DW'(n + 1);
      step();
    end
    idle();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    settle();
    chk("t2_err_cleared", DW'(sel_err_f), '0);
    for (int s = 0; s < 16; s++) begin
      rd_sel[SW-1:0] = SW'(s);
      settle();
      chk("t2_data", rd_data_f[DW-1:0], (s < NR) ? DW'(s + 1) : '0);
      chk("t2_sel_err", DW'(sel_err_f), DW'(s >= 14));
      step();
    end

    // 3: forwarding vs stored value
    rd_sel = {SW'(5), SW'(0)};
    wr_en = 1'b1; wr_sel = SW'(5); wr_data = 32'hDEAD_BEEF;
    settle();
    chk("t3_fwd", rd_data_f[DW +: DW], 32'hDEAD_BEEF);
    chk("t3_nofwd", rd_data_n[DW +: DW], 32'd6);
    step();
    idle();

    // 4: reserve then write
    rsv_en = 1'b1; rsv_sel = SW'(7);
    step();
    idle();
    rd_sel = {SW'(0), SW'(7)};
    settle();
    chk("t4_busy_vec7", DW'(busy_vec_f[7]), 32'd1);
    chk("t4_rd_busy", DW'(rd_busy_f[0]), 32'd1);
    step();
    wr_en = 1'b1; wr_sel = SW'(7); wr_data = 32'd42;
    step();
    idle();
    settle();
    chk("t4_busy_clr", DW'(busy_vec_f[7]), '0);
    chk("t4_data", rd_data_f[DW-1:0], 32'd42);
    step();

    // 5: reserve+write same register, error priority over clear
    rsv_en = 1'b1; rsv_sel = SW'(3); wr_en = 1'b1; wr_sel = SW'(3); wr_data = 32'd99;
    step();
    idle();
    rd_sel = {SW'(0), SW'(3)};
    settle();
    chk("t5_data", rd_data_f[DW-1:0], 32'd99);
    chk("t5_busy3", DW'(busy_vec_f[3]), 32'd1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b1; wr_en = 1'b1; wr_sel = SW'(14); wr_data = 32'h1234;
    step();
    idle();
    settle();
    chk("t5_err_priority", DW'(sel_err_f), 32'd1);
    step();

    // randomized phase
    for (int c = 0; c < 2000; c++) begin
      rd_sel  = {SW'($urandom_range(0, 15)), SW'($urandom_range(0, 15))};
      wr_en   = ($urandom_range(0, 1) == 1);
      wr_sel  = SW'($urandom_range(0, 15));
      wr_data = $urandom;
      rsv_en  = ($urandom_range(0, 2) == 0);
      rsv_sel = SW'($urandom_range(0, 15));
      err_clr = ($urandom_range(0, 7) == 0);
      step();
    end
    idle();
    rd_sel = '0;
    step();

    // 6: asynchronous reset mid-cycle with a write pending
    rd_sel = {SW'(2), SW'(2)};
    wr_en = 1'b1; wr_sel = SW'(2); wr_data = 32'd77;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_data_fwd", rd_data_f[DW-1:0], '0);
    chk("t6_data_nofwd", rd_data_n[DW-1:0], '0);
    chk("t6_busy_vec", DW'(busy_vec_f), '0);
    chk("t6_sel_err", DW'(sel_err_f), '0);
    step();
    rst_n = 1'b1;
    idle();
    settle();
    chk("t6_write_lost", rd_data_f[DW-1:0], '0);
    chk("t6_write_lost_nf", rd_data_n[DW-1:0], '0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
